regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-read-port integer register file with a pending-write scoreboard for the RISC-V core. It generalises the single-write, two-read register file:
- configurable data width, depth and number of read ports;
- registered reads with same-cycle write bypass;
- per-register busy bits, so the issue stage can see whether an operand is still waiting on a long-latency producer.

It sits between decode/issue and the execute/writeback stages.

## Interface
Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers. Must be a power of two, ≥2. AW = log2(NREGS) is derived internally, not a parameter.
- NRD, 2, number of read ports, ≥1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- wd_en  in  1  write enable.
- wd_sel  in  AW  write address.
- data  in  XLEN  write data.
- claim_en  in  1  mark a register busy (a long-latency producer has been issued).
- claim_sel  in  AW  register to claim.
- rd_en  in  1  read enable, common to all ports.
- rs_add  in  NRD*AW  read addresses; port i at [i*AW +: AW].
- rs  out  NRD*XLEN  registered read data; port i at [i*XLEN +: XLEN].
- rs_valid  out  NRD  registered per-port flag: operand is architecturally current (not busy).
- busy  out  NREGS  scoreboard vector; bit r = register r has a pending write.

## Operation
- Storage: NREGS × XLEN array plus an NREGS-bit busy vector.

Register 0:
- Hardwired zero. Writes to 0 are ignored.
- Claims of 0 are ignored, so busy[0] is always 0.
- Reads of 0 return 0 with rs_valid = 1.

Write:
- If wd_en and wd_sel ≠ 0, mem[wd_sel] <= data.
- busy[wd_sel] is cleared, unless a claim to the same register occurs in the same cycle.

Claim:
- If claim_en and claim_sel ≠ 0, busy[claim_sel] <= 1.
- Claim and write to the same register in the same cycle: data is written and busy stays/becomes 1. The claim wins because it belongs to a younger producer.

Read, per port i, with a = rs_add[i], when rd_en = 1:
- rs[i] <= 0 if a = 0.
- Otherwise rs[i] <= data if wd_en and wd_sel = a (write-through bypass).
- Otherwise rs[i] <= mem[a].
- rs_valid[i] <= 1 if a = 0.
- Otherwise rs_valid[i] <= 0 if claim_en and claim_sel = a.
- Otherwise rs_valid[i] <= 1 if wd_en and wd_sel = a.
- Otherwise rs_valid[i] <= ~busy[a].

Read general rules:
- rd_en = 0: rs and rs_valid hold their previous values.
- Several ports may read the same address; each port is independent.

busy output:
- Reflects the registered scoreboard state directly, with no bypass.

## Timing
- Read latency is 1 cycle: address presented in cycle N, rs/rs_valid valid after edge N.
- A write in cycle N is visible to a read issued in cycle N through the bypass, and to all later reads from the array.
- A claim in cycle N:
  - shows busy[r] = 1 after edge N;
  - a same-cycle read of r gives rs_valid = 0.
- rst = 1 at an edge dominates all other inputs. In that cycle:
  - every mem entry is cleared to 0;
  - busy is cleared to all 0;
  - rs is set to all 0;
  - rs_valid is set to all 0 (no read performed yet).
- Reset mid-operation discards any same-cycle write, claim or read.
- No combinational path from any input to any output.

## Test plan
- Reset then read: rst for 1 cycle, then rd_en with rs_add = {5, 0} → rs = {0, 0}, rs_valid = {1, 1}, busy = 0.
- Write/read-back: write 0xDEADBEEF to r7, next cycle read r7 on all ports → rs[i] = 0xDEADBEEF, rs_valid[i] = 1.
- Bypass and x0:
  - same cycle: write 0x1234 to r3 and read r3 → rs = 0x1234 next cycle;
  - write 0xFFFFFFFF to r0 → a later read of r0 returns 0.
- Scoreboard sequence on r9:
  - claim r9 → busy[9] = 1;
  - read r9 → rs_valid = 0;
  - write 0x55 to r9 → busy[9] = 0;
  - read r9 → rs = 0x55, rs_valid = 1.
- Claim and write collide on r4 in the same cycle with data 0xAA → mem[4] = 0xAA, busy[4] = 1; a same-cycle read of r4 gives rs = 0xAA, rs_valid = 0.
- Hold and mid-operation reset:
  - with rd_en = 0 after a read, rs is unchanged while the array is rewritten;
  - asserting rst during a write to r2 (0x77) → later read of r2 returns 0 and busy stays 0.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-read-port register file with registered reads, same-cycle write bypass
// and a per-register pending-write scoreboard. Register 0 is hardwired zero.
module regfile_mp #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned NRD   = 2,
  localparam int unsigned AW   = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wd_en,
  input  logic [AW-1:0]       wd_sel,
  input  logic [XLEN-1:0]     data,
  input  logic                claim_en,
  input  logic [AW-1:0]       claim_sel,
  input  logic                rd_en,
  input  logic [NRD*AW-1:0]   rs_add,
  output logic [NRD*XLEN-1:0] rs,
  output logic [NRD-1:0]      rs_valid,
  output logic [NREGS-1:0]    busy
);

  logic [XLEN-1:0]     mem [NREGS];
  logic                wr_hit;
  logic                cl_hit;
  logic [NRD*XLEN-1:0] rs_next;
  logic [NRD-1:0]      rs_valid_next;

  assign wr_hit = wd_en && (wd_sel != '0);
  assign cl_hit = claim_en && (claim_sel != '0);

  // Per-port read resolution: x0 first, then write bypass, then array.
  // Validity: a same-cycle claim beats a same-cycle write (younger producer).
  always_comb begin
    rs_next       = '0;
    rs_valid_next = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      if (rs_add[i*AW +: AW] == '0) begin
        rs_next[i*XLEN +: XLEN] = '0;
        rs_valid_next[i]        = 1'b1;
      end else begin
        if (wr_hit && (wd_sel == rs_add[i*AW +: AW]))
          rs_next[i*XLEN +: XLEN] = data;
        else
          rs_next[i*XLEN +: XLEN] = mem[rs_add[i*AW +: AW]];

        if (cl_hit && (claim_sel == rs_add[i*AW +: AW]))
          rs_valid_next[i] = 1'b0;
        else if (wr_hit && (wd_sel == rs_add[i*AW +: AW]))
          rs_valid_next[i] = 1'b1;
        else
          rs_valid_next[i] = ~busy[rs_add[i*AW +: AW]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREGS; r++)
        mem[r] <= '0;
      busy     <= '0;
      rs       <= '0;
      rs_valid <= '0;
    end else begin
      if (wr_hit) begin
        mem[wd_sel]  <= data;
        busy[wd_sel] <= 1'b0;
      end
      // Placed after the write so a same-register claim overrides the clear.
      if (cl_hit)
        busy[claim_sel] <= 1'b1;
      if (rd_en) begin
        rs       <= rs_next;
        rs_valid <= rs_valid_next;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: expected outputs are queued with each step
// and compared one cycle later against the registered outputs.
module tb_regfile_mp;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned NRD   = 2;
  localparam int unsigned AW    = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic                wd_en;
  logic [AW-1:0]       wd_sel;
  logic [XLEN-1:0]     data;
  logic                claim_en;
  logic [AW-1:0]       claim_sel;
  logic                rd_en;
  logic [NRD*AW-1:0]   rs_add;
  logic [NRD*XLEN-1:0] rs;
  logic [NRD-1:0]      rs_valid;
  logic [NREGS-1:0]    busy;

  typedef struct {
    string               tag;
    logic [NRD*XLEN-1:0] rs;
    logic [NRD-1:0]      rsv;
    logic [NREGS-1:0]    busy;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk(clk), .rst(rst), .wd_en(wd_en), .wd_sel(wd_sel), .data(data),
    .claim_en(claim_en), .claim_sel(claim_sel), .rd_en(rd_en),
    .rs_add(rs_add), .rs(rs), .rs_valid(rs_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic idle();
    rst = 1'b0; wd_en = 1'b0; wd_sel = '0; data = '0;
    claim_en = 1'b0; claim_sel = '0; rd_en = 1'b0; rs_add = '0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    wd_en = 1'b1; wd_sel = a; data = d;
  endtask

  task automatic cl(input logic [AW-1:0] a);
    claim_en = 1'b1; claim_sel = a;
  endtask

  task automatic rd(input logic [AW-1:0] p0, input logic [AW-1:0] p1);
    rd_en = 1'b1; rs_add = {p1, p0};
  endtask

  task automatic expect_out(input string tag, input logic [XLEN-1:0] rs1,
                            input logic [XLEN-1:0] rs0, input logic [1:0] rsv,
                            input logic [NREGS-1:0] b);
    exp_t e;
    e.tag = tag; e.rs = {rs1, rs0}; e.rsv = rsv; e.busy = b;
    q.push_back(e);
  endtask

  // Advance one edge, then compare everything queued for it.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    tests++;
    assert (q.size() == 1) else begin
      fails++;
      $error("FAIL %s queue: got %0d entries, want 1", "scoreboard", q.size());
    end
    if (q.size() != 0) begin
      e = q.pop_front();
      tests++;
      assert (rs === e.rs) else begin
        fails++;
        $error("FAIL %s rs: got %h want %h", e.tag, rs, e.rs);
      end
      tests++;
      assert (rs_valid === e.rsv) else begin
        fails++;
        $error("FAIL %s rs_valid: got %b want %b", e.tag, rs_valid, e.rsv);
      end
      tests++;
      assert (busy === e.busy) else begin
        fails++;
        $error("FAIL %s busy: got %h want %h", e.tag, busy, e.busy);
      end
    end
    q.delete();
    idle();
  endtask

  localparam logic [NREGS-1:0] B9 = 32'h0000_0200;
  localparam logic [NREGS-1:0] B4 = 32'h0000_0010;

  initial begin
    idle();
    rst = 1'b1; wr(5'd6, 32'h1111_1111); cl(5'd6); rd(5'd6, 5'd6);
    expect_out("reset", '0, '0, 2'b00, '0); step();

    rd(5'd0, 5'd5);
    expect_out("read_after_reset", '0, '0, 2'b11, '0); step();

    wr(5'd7, 32'hDEAD_BEEF);
    expect_out("hold_during_write", '0, '0, 2'b11, '0); step();

    rd(5'd7, 5'd7);
    expect_out("readback_r7", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b11, '0); step();

    wr(5'd3, 32'h0000_1234); rd(5'd3, 5'd3);
    expect_out("bypass_r3", 32'h1234, 32'h1234, 2'b11, '0); step();

    wr(5'd0, 32'hFFFF_FFFF); rd(5'd0, 5'd7);
    expect_out("write_r0_same", 32'hDEAD_BEEF, '0, 2'b11, '0); step();

    rd(5'd3, 5'd0);
    expect_out("read_r0_later", '0, 32'h1234, 2'b11, '0); step();

    cl(5'd9); rd(5'd7, 5'd9);
    expect_out("claim_r9", '0, 32'hDEAD_BEEF, 2'b01, B9); step();

    rd(5'd9, 5'd9);
    expect_out("read_busy_r9", '0, '0, 2'b00, B9); step();

    wr(5'd9, 32'h55);
    expect_out("write_r9_clears", '0, '0, 2'b00, '0); step();

    rd(5'd0, 5'd9);
    expect_out("read_r9_done", 32'h55, '0, 2'b11, '0); step();

    wr(5'd4, 32'hAA); cl(5'd4); rd(5'd4, 5'd4);
    expect_out("collide_r4", 32'hAA, 32'hAA, 2'b00, B4); step();

    rd(5'd3, 5'd4);
    expect_out("r4_still_busy", 32'hAA, 32'h1234, 2'b01, B4); step();

    wr(5'd3, 32'hBEEF);
    expect_out("hold_rewrite", 32'hAA, 32'h1234, 2'b01, B4); step();

    wr(5'd4, 32'h11); rd(5'd3, 5'd4);
    expect_out("write_busy_bypass", 32'h11, 32'hBEEF, 2'b11, '0); step();

    cl(5'd0); rd(5'd0, 5'd0);
    expect_out("claim_r0", '0, '0, 2'b11, '0); step();

    rst = 1'b1; wr(5'd2, 32'h77); cl(5'd5); rd(5'd2, 5'd2);
    expect_out("reset_mid_op", '0, '0, 2'b00, '0); step();

    rd(5'd7, 5'd2);
    expect_out("after_reset_r2", '0, '0, 2'b11, '0); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1, "watchdog");
  end

endmodule
